// File: rtl/quar_sequencer_if.sv
// Signal bundle between the quarantine sequencer, the board button and the LED countdown block.
interface quar_sequencer_if;
    logic       btnC;
    logic       resetQUAR;
    logic       QUAR;
    logic       resetFLAG;
    logic       tick;
    logic       busy;
    logic       lockout;
    logic [7:0] event_count;

    modport master (
        input  btnC, resetQUAR,
        output QUAR, resetFLAG, tick, busy, lockout, event_count
    );

    modport slave (
        output btnC, resetQUAR,
        input  QUAR, resetFLAG, tick, busy, lockout, event_count
    );
endinterface

// File: rtl/quar_sequencer.sv
// Quarantine countdown controller: button debounce, QUAR/resetFLAG handshake,
// countdown tick generation and post-countdown lockout, all on one clock.
module quar_sequencer #(
    parameter int TICK_DIV        = 134_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int COOLDOWN_TICKS  = 2
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    quar_sequencer_if.master io_seq
);
    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CD_W  = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0]  CD_LAST      = CD_W'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);
    localparam bit               HAS_COOLDOWN = (COOLDOWN_TICKS > 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_ACK      = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_sync;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_deb;
    logic             r_deb_prev;
    logic [DIV_W-1:0] r_div;
    logic [CD_W-1:0]  r_cd_cnt;
    logic             r_quar;
    logic             r_flag;
    logic             r_tick;
    logic             r_busy;
    logic             r_lockout;
    logic [7:0]       r_event_count;
    logic             w_sync;
    logic             w_press;
    logic             w_div_active;
    logic             w_tick_evt;

    assign w_sync       = r_sync[1];
    assign w_press      = r_deb & ~r_deb_prev;
    assign w_div_active = (r_state == S_RUN) || (r_state == S_COOLDOWN);
    assign w_tick_evt   = w_div_active && (r_div == DIV_LAST);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync     <= 2'b00;
            r_deb_cnt  <= '0;
            r_deb      <= 1'b0;
            r_deb_prev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], io_seq.btnC};
            r_deb_prev <= r_deb;
            // Any sample agreeing with the accepted level restarts the stability count.
            if (w_sync == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb     <= w_sync;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (io_seq.resetQUAR) begin
                    w_state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (!io_seq.resetQUAR) begin
                    w_state_next = HAS_COOLDOWN ? S_COOLDOWN : S_IDLE;
                end
            end
            S_COOLDOWN: begin
                // Presses arriving here, even on the final tick, are dropped.
                if (w_tick_evt && (r_cd_cnt == CD_LAST)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div         <= '0;
            r_cd_cnt      <= '0;
            r_quar        <= 1'b0;
            r_flag        <= 1'b0;
            r_tick        <= 1'b0;
            r_busy        <= 1'b0;
            r_lockout     <= 1'b0;
            r_event_count <= 8'd0;
        end else begin
            // Divider idles at zero outside RUN/COOLDOWN, so each entry starts a full period.
            if (!w_div_active || w_tick_evt || (w_state_next != r_state)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            if (r_state != S_COOLDOWN) begin
                r_cd_cnt <= '0;
            end else if (w_tick_evt) begin
                r_cd_cnt <= (r_cd_cnt == CD_LAST) ? '0 : r_cd_cnt + CD_W'(1);
            end

            r_tick    <= w_tick_evt;
            r_quar    <= (w_state_next == S_RUN);
            r_flag    <= (w_state_next == S_ACK);
            r_busy    <= (w_state_next == S_RUN) || (w_state_next == S_ACK);
            r_lockout <= (w_state_next == S_COOLDOWN);

            if ((r_state == S_IDLE) && (w_state_next == S_RUN) && (r_event_count != 8'hFF)) begin
                r_event_count <= r_event_count + 8'd1;
            end
        end
    end

    assign io_seq.QUAR        = r_quar;
    assign io_seq.resetFLAG   = r_flag;
    assign io_seq.tick        = r_tick;
    assign io_seq.busy        = r_busy;
    assign io_seq.lockout     = r_lockout;
    assign io_seq.event_count = r_event_count;
endmodule

// File: tb/tb_quar_sequencer.sv
// Bench for quar_sequencer: glitch table, handshake/cooldown sequences, async reset, counter saturation.
module tb_quar_sequencer;
    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;
    int   exp_tick_q[$];

    quar_sequencer_if a_if();
    quar_sequencer_if b_if();

    quar_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3), .COOLDOWN_TICKS(2)) u_dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .io_seq  (a_if)
    );

    quar_sequencer #(.TICK_DIV(2), .DEBOUNCE_CYCLES(3), .COOLDOWN_TICKS(2)) u_dut_sat (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .io_seq  (b_if)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] pat;
        logic [3:0] len;
        logic       exp_quar;
        logic       exp_busy;
        logic [7:0] exp_ec;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic at_neg(input int n);
        goto(n);
        @(negedge CLOCK);
    endtask

    // Tick scoreboard plus output exclusivity on every cycle.
    always @(negedge CLOCK) begin
        if (a_if.tick === 1'b1) begin
            if (exp_tick_q.size() == 0) begin
                check("tick_unexpected", cyc, -1);
            end else begin
                check("tick_cycle", cyc, exp_tick_q.pop_front());
            end
        end
        if (RESET_N) begin
            check("busy_lockout_excl", a_if.busy & a_if.lockout, 0);
            check("quar_flag_excl", a_if.QUAR & a_if.resetFLAG, 0);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int t;
        int u;
        int k;
        int exp_ec;

        a_if.btnC = 1'b0; a_if.resetQUAR = 1'b0;
        b_if.btnC = 1'b0; b_if.resetQUAR = 1'b0;

        vecs[0] = '{pat: 8'b0000_0011, len: 4'd2, exp_quar: 1'b0, exp_busy: 1'b0, exp_ec: 8'd0};
        vecs[1] = '{pat: 8'b0000_0101, len: 4'd4, exp_quar: 1'b0, exp_busy: 1'b0, exp_ec: 8'd0};
        vecs[2] = '{pat: 8'b0000_1101, len: 4'd4, exp_quar: 1'b0, exp_busy: 1'b0, exp_ec: 8'd0};
        vecs[3] = '{pat: 8'b0001_1011, len: 4'd6, exp_quar: 1'b0, exp_busy: 1'b0, exp_ec: 8'd0};

        repeat (2) @(negedge CLOCK);
        check("rst_quar", a_if.QUAR, 0);
        check("rst_flag", a_if.resetFLAG, 0);
        check("rst_tick", a_if.tick, 0);
        check("rst_busy", a_if.busy, 0);
        check("rst_lockout", a_if.lockout, 0);
        check("rst_event_count", a_if.event_count, 0);
        #2 RESET_N = 1'b1;
        goto(cyc + 2);

        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < int'(vecs[i].len); b++) begin
                a_if.btnC = vecs[i].pat[b];
                goto(cyc + 1);
            end
            a_if.btnC = 1'b0;
            goto(cyc + 8);
            @(negedge CLOCK);
            $display("vector %0d: pat=%b len=%0d quar=%0d busy=%0d ec=%0d", i, vecs[i].pat, vecs[i].len,
                     a_if.QUAR, a_if.busy, a_if.event_count);
            check("vec_quar", a_if.QUAR, vecs[i].exp_quar);
            check("vec_busy", a_if.busy, vecs[i].exp_busy);
            check("vec_event_count", a_if.event_count, vecs[i].exp_ec);
        end

        // Run 1: clean press, tick coinciding with resetQUAR, ACK hold, cooldown.
        goto(cyc + 1);
        c = cyc;
        a_if.btnC = 1'b1;
        exp_tick_q.push_back(c + 10);
        exp_tick_q.push_back(c + 14);
        exp_tick_q.push_back(c + 18);
        exp_tick_q.push_back(c + 22);
        exp_tick_q.push_back(c + 31);
        exp_tick_q.push_back(c + 35);
        at_neg(c + 5);  check("quar_before_debounce", a_if.QUAR, 0);
        at_neg(c + 6);  check("quar_rise", a_if.QUAR, 1);
                        check("busy_run", a_if.busy, 1);
                        check("event_count_first", a_if.event_count, 1);
        goto(c + 10);   a_if.btnC = 1'b0;
        goto(c + 21);   a_if.resetQUAR = 1'b1;
        at_neg(c + 21); check("quar_still_high", a_if.QUAR, 1);
        at_neg(c + 22); check("ack_quar_low", a_if.QUAR, 0);
                        check("ack_flag_high", a_if.resetFLAG, 1);
        goto(c + 26);   a_if.resetQUAR = 1'b0;
        at_neg(c + 26); check("ack_flag_held", a_if.resetFLAG, 1);
        at_neg(c + 27); check("flag_fall", a_if.resetFLAG, 0);
                        check("lockout_rise", a_if.lockout, 1);
                        check("busy_cooldown", a_if.busy, 0);
        at_neg(c + 34); check("lockout_held", a_if.lockout, 1);
        at_neg(c + 35); check("lockout_fall", a_if.lockout, 0);
                        check("event_count_run1", a_if.event_count, 1);
        $display("run1 done at cycle %0d", cyc);

        // Run 2: presses during ACK and on the final cooldown tick are discarded.
        goto(c + 40);
        t = cyc;
        a_if.btnC = 1'b1;
        exp_tick_q.push_back(t + 30);
        exp_tick_q.push_back(t + 34);
        at_neg(t + 6);  check("run2_quar", a_if.QUAR, 1);
                        check("run2_event_count", a_if.event_count, 2);
        goto(t + 7);    a_if.resetQUAR = 1'b1;
        at_neg(t + 8);  check("run2_ack", a_if.resetFLAG, 1);
        goto(t + 10);   a_if.btnC = 1'b0;
        goto(t + 16);   a_if.btnC = 1'b1;
        goto(t + 22);   a_if.btnC = 1'b0;
        at_neg(t + 23); check("ack_press_quar", a_if.QUAR, 0);
                        check("ack_press_flag", a_if.resetFLAG, 1);
                        check("ack_press_count", a_if.event_count, 2);
        goto(t + 25);   a_if.resetQUAR = 1'b0;
        at_neg(t + 26); check("run2_lockout", a_if.lockout, 1);
        goto(t + 28);   a_if.btnC = 1'b1;
        goto(t + 32);   a_if.btnC = 1'b0;
        at_neg(t + 33); check("run2_lockout_held", a_if.lockout, 1);
        at_neg(t + 34); check("run2_lockout_fall", a_if.lockout, 0);
        at_neg(t + 36); check("cd_press_quar", a_if.QUAR, 0);
                        check("cd_press_busy", a_if.busy, 0);
                        check("cd_press_count", a_if.event_count, 2);
        $display("run2 done at cycle %0d", cyc);

        // Run 3: fresh press starts a run, then asynchronous reset while a tick is high.
        goto(t + 40);
        u = cyc;
        a_if.btnC = 1'b1;
        at_neg(u + 6);  check("run3_quar", a_if.QUAR, 1);
                        check("run3_event_count", a_if.event_count, 3);
        goto(u + 10);   a_if.btnC = 1'b0;
        check("tick_before_reset", a_if.tick, 1);
        #2 RESET_N = 1'b0;
        #1;
        check("arst_quar", a_if.QUAR, 0);
        check("arst_busy", a_if.busy, 0);
        check("arst_tick", a_if.tick, 0);
        check("arst_flag", a_if.resetFLAG, 0);
        check("arst_lockout", a_if.lockout, 0);
        check("arst_event_count", a_if.event_count, 0);
        @(negedge CLOCK);
        #2 RESET_N = 1'b1;
        goto(cyc + 10);
        @(negedge CLOCK);
        check("post_rst_quar", a_if.QUAR, 0);
        check("post_rst_busy", a_if.busy, 0);
        check("post_rst_count", a_if.event_count, 0);
        check("tick_scoreboard_empty", exp_tick_q.size(), 0);
        $display("reset sequence done at cycle %0d", cyc);

        // Saturation: 257 complete runs on the TICK_DIV=2 instance.
        for (int i = 0; i < 257; i++) begin
            b_if.btnC = 1'b1;
            k = 0;
            while (b_if.QUAR !== 1'b1 && k < 20) begin @(negedge CLOCK); k++; end
            check("sat_quar", b_if.QUAR, 1);
            b_if.btnC = 1'b0;
            exp_ec = (i + 1 > 255) ? 255 : i + 1;
            check("sat_event_count", b_if.event_count, exp_ec);
            if (i >= 254) begin
                $display("sat run %0d: event_count=%0d", i, b_if.event_count);
            end
            b_if.resetQUAR = 1'b1;
            k = 0;
            while (b_if.resetFLAG !== 1'b1 && k < 20) begin @(negedge CLOCK); k++; end
            check("sat_flag", b_if.resetFLAG, 1);
            b_if.resetQUAR = 1'b0;
            k = 0;
            while ((b_if.busy !== 1'b0 || b_if.lockout !== 1'b0) && k < 30) begin @(negedge CLOCK); k++; end
            check("sat_idle", {b_if.busy, b_if.lockout}, 0);
            if (b_if.QUAR !== 1'b0 || b_if.busy !== 1'b0) break;
            repeat (6) @(negedge CLOCK);
        end
        check("sat_final", b_if.event_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
